// File: rtl/led_pkg.sv
// Constants and decoder state encoding shared by the LED sweep generator and
// the LED sweep decoder.
package led_pkg;

  localparam logic LED_LEFT  = 1'b1;
  localparam logic LED_RIGHT = 1'b0;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } dec_state_e;

endpackage

// File: rtl/onehot_to_index.sv
// Combinational one-hot decoder: returns the index of the set bit and flags
// whether exactly one bit is set.
module onehot_to_index #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  onehot_i,
  output logic [IW-1:0] index_o,
  output logic          valid_o
);

  always_comb begin
    index_o = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_i[i]) begin
        index_o = IW'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign valid_o = (onehot_i != '0) && ((onehot_i & (onehot_i - 1'b1)) == '0);

endmodule

// File: rtl/led_sweep_decoder.sv
// Decodes a one-hot LED sweep bus into position and direction, checks for
// legal bounce motion and counts end-of-bar reversals.
module led_sweep_decoder
  import led_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [N-1:0]         led_in,
  input  logic                 err_clr,
  output logic [$clog2(N)-1:0] pos,
  output logic                 pos_valid,
  output logic                 dir,
  output logic                 locked,
  output logic                 step_err,
  output logic                 onehot_err,
  output logic                 err_sticky,
  output logic [CNT_W-1:0]     bounce_cnt
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW:0]   ONE  = (IW + 1)'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  dec_state_e       state_q, state_d;
  logic [IW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_err_q, step_err_d;
  logic             onehot_err_q, onehot_err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  logic [IW-1:0] dec_idx;
  logic          dec_valid;
  logic [IW-1:0] exp_idx;
  logic          at_end;
  logic          adjacent;
  logic          bounce;
  logic [IW:0]   pos_ext, idx_ext;

  onehot_to_index #(
    .N  (N),
    .IW (IW)
  ) u_decode (
    .onehot_i (led_in),
    .index_o  (dec_idx),
    .valid_o  (dec_valid)
  );

  assign pos_ext  = {1'b0, pos_q};
  assign idx_ext  = {1'b0, dec_idx};
  assign adjacent = (idx_ext == pos_ext + ONE) || (pos_ext == idx_ext + ONE);
  assign at_end   = ((dir_q == LED_LEFT)  && (pos_q == LAST)) ||
                    ((dir_q == LED_RIGHT) && (pos_q == '0));

  always_comb begin
    exp_idx = pos_q;
    if (dir_q == LED_LEFT) begin
      exp_idx = at_end ? LAST - 1'b1 : pos_q + 1'b1;
    end else begin
      exp_idx = at_end ? IW'(1) : pos_q - 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= UNLOCKED;
      pos_q        <= '0;
      dir_q        <= LED_RIGHT;
      step_err_q   <= 1'b0;
      onehot_err_q <= 1'b0;
      sticky_q     <= 1'b0;
      bcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      step_err_q   <= step_err_d;
      onehot_err_q <= onehot_err_d;
      sticky_q     <= sticky_d;
      bcnt_q       <= bcnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    step_err_d   = 1'b0;
    onehot_err_d = 1'b0;
    bounce       = 1'b0;

    if (sample_en) begin
      if (!dec_valid) begin
        onehot_err_d = 1'b1;
        state_d      = UNLOCKED;
      end else begin
        unique case (state_q)
          UNLOCKED: begin
            pos_d   = dec_idx;
            state_d = ACQUIRE;
          end
          ACQUIRE: begin
            pos_d = dec_idx;
            if (adjacent) begin
              dir_d   = (dec_idx > pos_q) ? LED_LEFT : LED_RIGHT;
              state_d = LOCKED;
            end else begin
              step_err_d = 1'b1;
            end
          end
          LOCKED: begin
            pos_d = dec_idx;
            if (dec_idx == exp_idx) begin
              if (at_end) begin
                dir_d  = ~dir_q;
                bounce = 1'b1;
              end
            end else begin
              step_err_d = 1'b1;
              state_d    = ACQUIRE;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end
  end

  // A same-cycle error or bounce takes precedence over err_clr.
  always_comb begin
    sticky_d = sticky_q;
    if (step_err_d || onehot_err_d) begin
      sticky_d = 1'b1;
    end else if (err_clr) begin
      sticky_d = 1'b0;
    end

    bcnt_d = bcnt_q;
    if (bounce) begin
      bcnt_d = err_clr ? CNT_W'(1) : sat_inc(bcnt_q);
    end else if (err_clr) begin
      bcnt_d = '0;
    end
  end

  always_comb begin
    pos        = pos_q;
    pos_valid  = (state_q != UNLOCKED);
    dir        = dir_q;
    locked     = (state_q == LOCKED);
    step_err   = step_err_q;
    onehot_err = onehot_err_q;
    err_sticky = sticky_q;
    bounce_cnt = bcnt_q;
  end

endmodule
